// File: rtl/alu_cmd_sequencer_if.sv
// Bundles the command, ALU, result and status signals of the ALU command sequencer.
// The slave modport is the sequencer side and the master modport is the environment side.
interface alu_cmd_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_opcode;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;

  logic [3:0] alu_opcode;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_x;
  logic [3:0] alu_y;

  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_opcode;
  logic       res_zero;

  logic       busy;
  logic [7:0] issued_count;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_x, alu_y, res_ready,
    output cmd_ready, alu_opcode, alu_a, alu_b,
    output res_valid, res_data, res_opcode, res_zero, busy, issued_count
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, alu_x, alu_y, res_ready,
    input  cmd_ready, alu_opcode, alu_a, alu_b,
    input  res_valid, res_data, res_opcode, res_zero, busy, issued_count
  );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one at a time, captures masked {y,x}; result SETTLE_CYCLES+1 edges after push.
// cmd_ready drops when the FIFO is full; a held result (res_ready=0) stalls further issue.
module alu_cmd_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  // Push is gated by full only, so a same-cycle pop never frees room for a push.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

module alu_cmd_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  bus
);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [3:0]    alu_a_q, alu_a_d;
  logic [3:0]    alu_b_q, alu_b_d;
  logic          res_valid_q, res_valid_d;
  logic [7:0]    res_data_q, res_data_d;
  logic [3:0]    res_op_q, res_op_d;
  logic          res_zero_q, res_zero_d;
  logic [7:0]    issued_q, issued_d;

  cmd_t fifo_wdata;
  cmd_t fifo_rdata;
  logic fifo_full;
  logic fifo_empty;
  logic pop;
  logic capture;

  function automatic logic [7:0] mask_result(input logic [3:0] op, input logic [3:0] x,
                                             input logic [3:0] y);
    logic [7:0] r;
    case (op)
      4'h3, 4'h4, 4'h5, 4'hB, 4'hF: r = {4'b0, x};
      4'hA:                         r = {3'b0, y[0], x};
      4'hC, 4'hD, 4'hE:             r = {y, x};
      default:                      r = {7'b0, x[0]};
    endcase
    return r;
  endfunction

  assign fifo_wdata = '{opcode: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b};

  alu_cmd_fifo #(
    .W     ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.cmd_valid),
    .pop_i   (pop),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_zero_q  <= 1'b0;
      issued_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_zero_q  <= res_zero_d;
      issued_q    <= issued_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty) state_d = SETTLE;
      SETTLE:  if (cnt_q == '0) state_d = HOLD;
      HOLD:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop         = (state_q == IDLE) && !fifo_empty;
    capture     = (state_q == SETTLE) && (cnt_q == '0);
    cnt_d       = cnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_zero_d  = res_zero_q;
    issued_d    = issued_q;
    if (pop) begin
      alu_op_d = fifo_rdata.opcode;
      alu_a_d  = fifo_rdata.a;
      alu_b_d  = fifo_rdata.b;
      cnt_d    = SW'(SETTLE_CYCLES - 1);
    end
    if (state_q == SETTLE && cnt_q != '0) begin
      cnt_d = cnt_q - SW'(1);
    end
    if (capture) begin
      res_data_d  = mask_result(alu_op_q, bus.alu_x, bus.alu_y);
      res_zero_d  = (mask_result(alu_op_q, bus.alu_x, bus.alu_y) == 8'h00);
      res_op_d    = alu_op_q;
      res_valid_d = 1'b1;
      issued_d    = issued_q + 8'd1;
    end
    if (state_q == HOLD && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  assign bus.cmd_ready    = !fifo_full;
  assign bus.alu_opcode   = alu_op_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.res_valid    = res_valid_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_opcode   = res_op_q;
  assign bus.res_zero     = res_zero_q;
  assign bus.busy         = (state_q != IDLE) || !fifo_empty;
  assign bus.issued_count = issued_q;
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Sequential front-end for the team's 4-bit opcode ALU, the command-issuing and result-collecting side of its a/b/opcode → x/y interface.
- Accepts ALU commands through a valid/ready handshake and buffers them in a small FIFO.
- Drives one command at a time onto the ALU ports, waits a settle interval, then captures {y,x}.
- Masks the capture to the bits each opcode actually defines and returns an 8-bit result through a second valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)
- SETTLE_CYCLES, 1, clock edges the ALU inputs are held before capture (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  FIFO can accept (= !full, combinational from FIFO count)
- cmd_opcode  input  4  ALU opcode
- cmd_a  input  4  operand a
- cmd_b  input  4  operand b
- alu_opcode  output  4  registered opcode to ALU
- alu_a  output  4  registered operand a to ALU
- alu_b  output  4  registered operand b to ALU
- alu_x  input  4  ALU x result
- alu_y  input  4  ALU y result
- res_valid  output  1  result present
- res_ready  input  1  result consumer ready
- res_data  output  8  masked result
- res_opcode  output  4  opcode of the result
- res_zero  output  1  res_data == 0
- busy  output  1  FSM not IDLE or FIFO non-empty
- issued_count  output  8  completed captures, wraps 255→0

Behaviour:
- Reset (async, rst=1): FIFO empty, FSM=IDLE. All outputs 0: alu_* = 0, res_* = 0, issued_count = 0, busy = 0. cmd_ready = 1 once FIFO is empty.
- Push: on a rising edge with cmd_valid && cmd_ready, write {opcode,a,b}. When full, cmd_ready=0 and the command is not taken. A same-cycle pop does not enable a push into a full FIFO.
- FSM states: IDLE, SETTLE, CAPTURE(implicit), HOLD.
- IDLE: if FIFO non-empty at an edge, pop head into alu_opcode/alu_a/alu_b, set settle counter = SETTLE_CYCLES-1, go SETTLE. Otherwise stay.
- SETTLE: at each edge, if counter == 0, capture alu_x/alu_y into res_data per mask, load res_opcode, set res_valid=1, increment issued_count, go HOLD. Otherwise decrement.
- HOLD: res_data/res_opcode/res_zero stable while res_valid && !res_ready. On the edge with res_ready=1: res_valid←0, go IDLE. The next pop occurs at the following edge.
- alu_* outputs keep the last issued command after completion. They do not return to 0.
- Latency: with SETTLE_CYCLES=1 and an empty idle block, a command pushed at edge E0 is popped at E1 and res_valid rises at E2. In general, res_valid rises SETTLE_CYCLES+1 edges after the push.
- Result mask (X=alu_x, Y=alu_y):
  - 0000,0001,0010,0110,0111,1000,1001 → {7'b0, X[0]}
  - 0011,0100,0101,1011,1111 → {4'b0, X}
  - 1010 → {3'b0, Y[0], X}
  - 1100,1101,1110 → {Y, X}
- res_zero = (res_data == 8'h00), registered with res_data.
- Capacity: 1 command in SETTLE/HOLD plus FIFO_DEPTH in the FIFO.
- Reset mid-operation: FIFO contents and the in-flight command are discarded, and all outputs return to reset values immediately.

Test Plan:
- Reset check: assert rst mid-SETTLE with 3 entries queued → res_valid=0, issued_count=0, alu_opcode=0, busy=0 and cmd_ready=1 after rst drops, and no stale result ever appears.
- AND 0011 a=4'hC b=4'hA, res_ready=1, behavioural ALU model → res_valid at E2, res_data=8'h08, res_zero=0, issued_count=1.
- ADD 1010 a=4'hF b=4'h1 → res_data=8'h10. MUL 1100 a=F b=F → 8'hE1. SHL 1110 a=9 b=2 → 8'h24.
- Masking: GT 0110 a=5 b=3 while the ALU model drives alu_x=4'b1011 and alu_y=4'hF → res_data=8'h01. NOT-logical 1000 a=0 → 8'h01, and a=3 → 8'h00 with res_zero=1.
- Backpressure: res_ready=0, drive 7 back-to-back commands → exactly 5 accepted (1 in HOLD, 4 in FIFO) and cmd_ready=0 from then on. Pulse res_ready once per result → all 5 results emerge in order with res_opcode matching and the remaining 2 commands accepted as space frees.
- Wrap: 256 completed commands → issued_count returns to 8'h00.
